// File: rtl/secuenciador_spi_pkg.sv
// rtl/secuenciador_spi_pkg.sv - shared types and constants for the SPI transaction sequencer
//
// Purpose: state encoding, transfer-mode encodings, control-word bit positions
// and a helper that builds the control word written to the SPI core.
// Ports: none (package).

package secuenciador_spi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CFG,
    POLL_A,
    POLL_S,
    ABORT,
    RD_A,
    RD_S,
    RD_OUT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] MODE_BUF   = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_BAD   = 2'b11;

  localparam int CTRL_SEND     = 0;
  localparam int CTRL_ALL1     = 2;
  localparam int CTRL_ALL0     = 3;
  localparam int CTRL_NEND_LSB = 4;
  localparam int CTRL_NEND_MSB = 12;

  // Control word that launches a transfer: byte count minus one in the NEND
  // field (9-bit arithmetic, so 256 bytes encodes as 0xFF), fill-pattern
  // select bits and the send bit.
  function automatic logic [31:0] ctrl_word(input logic [8:0] n_bytes,
                                            input logic [1:0] mode);
    logic [31:0] w;
    logic [8:0]  n_m1;
    w    = '0;
    n_m1 = n_bytes - 9'd1;
    w[CTRL_NEND_MSB:CTRL_NEND_LSB] = n_m1;
    w[CTRL_ALL0] = (mode == MODE_ZEROS);
    w[CTRL_ALL1] = (mode == MODE_ONES);
    w[CTRL_SEND] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/secuenciador_spi_timeout.sv
// rtl/secuenciador_spi_timeout.sv - loadable down-counter with expiry flag for the poll timeout
//
// Purpose: counts poll cycles down from a loaded value and flags when zero is
// reached; the counter saturates at zero.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load load_val (wins over dec)
//   load_val in  WIDTH  start value
//   dec      in  decrement by one while nonzero
//   expired  out count is zero

module contador_timeout #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/secuenciador_spi.sv
// rtl/secuenciador_spi.sv - host-side transaction sequencer for the SPI controller register map
//
// Purpose: turns a start/busy/done handshake plus tx/rx byte streams into the
// register-level sequence the SPI core expects: load buffer, write control with
// send=1, poll send until clear (with timeout/abort), read back the buffer.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, n_bytes_i, mode_i   transaction request (sampled in IDLE)
//   tx_byte_i/tx_valid_i/tx_ready_o  tx byte stream into the buffer
//   rx_byte_o/rx_valid_o/rx_ready_i  rx byte stream out of the buffer
//   busy_o, done_o, error_o      status; error_o sticky until next accepted start
//   reg_sel_o, wr_o, entrada_o, addr_o, bits_salida_i  SPI core register bus

module secuenciador_spi
  import secuenciador_spi_pkg::*;
#(
  parameter int MAX_BYTES   = 256,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [8:0]  n_bytes_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  tx_byte_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        reg_sel_o,
  output logic        wr_o,
  output logic [31:0] entrada_o,
  output logic [31:0] addr_o,
  input  logic [31:0] bits_salida_i
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t      state;
  logic [8:0]  n_q;
  logic [1:0]  mode_q;
  logic [8:0]  k;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic        sel_q;
  logic        ready_q;
  logic [7:0]  rx_q;
  logic        rx_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic start_legal;
  logic last;
  logic tx_fire;
  logic tmo_expired;
  logic unused_rd;

  assign start_legal = (n_bytes_i != 9'd0)
                    && ({23'd0, n_bytes_i} <= 32'(MAX_BYTES))
                    && (mode_i != MODE_BAD);
  assign last        = (k == (n_q - 9'd1));
  assign tx_fire     = ready_q & tx_valid_i;
  assign unused_rd   = ^bits_salida_i[31:8];

  // The poll window is T cycles long counting both address and sample phases;
  // loading T-1 while in CFG makes the counter hit zero on the T-th poll cycle.
  contador_timeout #(
    .WIDTH(TW)
  ) u_timeout (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (state == CFG),
    .load_val(TW'(TIMEOUT_CYC - 1)),
    .dec     ((state == POLL_A) || (state == POLL_S)),
    .expired (tmo_expired)
  );

  // Buffer loads are accepted in the same cycle the tx byte is offered, so the
  // write strobe and data bypass the registers while in LOAD. Everything else
  // on the bus comes straight from registers.
  assign tx_ready_o = ready_q;
  assign wr_o       = wr_q | tx_fire;
  assign reg_sel_o  = sel_q;
  assign addr_o     = {24'd0, addr_q};
  assign entrada_o  = tx_fire ? {24'd0, tx_byte_i} : data_q;
  assign rx_byte_o  = rx_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      n_q        <= '0;
      mode_q     <= MODE_BUF;
      k          <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      sel_q      <= 1'b0;
      ready_q    <= 1'b0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (start_legal) begin
              n_q     <= n_bytes_i;
              mode_q  <= mode_i;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              k       <= '0;
              addr_q  <= '0;
              if (mode_i == MODE_BUF) begin
                state   <= LOAD;
                ready_q <= 1'b1;
                sel_q   <= 1'b1;
              end else begin
                state  <= CFG;
                wr_q   <= 1'b1;
                sel_q  <= 1'b0;
                data_q <= ctrl_word(n_bytes_i, mode_i);
              end
            end else begin
              state   <= ERR;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (tx_fire) begin
            if (last) begin
              state   <= CFG;
              ready_q <= 1'b0;
              sel_q   <= 1'b0;
              addr_q  <= '0;
              k       <= '0;
              wr_q    <= 1'b1;
              data_q  <= ctrl_word(n_q, mode_q);
            end else begin
              k      <= k + 9'd1;
              addr_q <= addr_q + 8'd1;
            end
          end
        end

        CFG: begin
          state  <= POLL_A;
          wr_q   <= 1'b0;
          data_q <= '0;
        end

        POLL_A: begin
          if (tmo_expired) begin
            state  <= ABORT;
            wr_q   <= 1'b1;
            data_q <= '0;
          end else begin
            state <= POLL_S;
          end
        end

        // Read data here reflects the control register addressed in POLL_A.
        POLL_S: begin
          if (!bits_salida_i[CTRL_SEND]) begin
            state  <= RD_A;
            sel_q  <= 1'b1;
            addr_q <= '0;
            k      <= '0;
          end else if (tmo_expired) begin
            state  <= ABORT;
            wr_q   <= 1'b1;
            data_q <= '0;
          end else begin
            state <= POLL_A;
          end
        end

        ABORT: begin
          state   <= ERR;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          error_q <= 1'b1;
        end

        RD_A: begin
          state <= RD_S;
        end

        // Capture byte k and immediately present address k+1, so the next
        // byte's read data is already waiting when the downstream accepts.
        RD_S: begin
          rx_q       <= bits_salida_i[7:0];
          rx_valid_q <= 1'b1;
          state      <= RD_OUT;
          if (!last) begin
            addr_q <= addr_q + 8'd1;
          end
        end

        RD_OUT: begin
          if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
              sel_q  <= 1'b0;
              addr_q <= '0;
            end else begin
              k     <= k + 9'd1;
              state <= RD_S;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        ERR: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_spi.sv
// tb/tb_secuenciador_spi.sv - randomized self-checking bench for secuenciador_spi

module tb_secuenciador_spi;

  localparam int TMO = 64;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  n_bytes_i;
  logic [1:0]  mode_i;
  logic [7:0]  tx_byte_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_byte_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        reg_sel_o;
  logic        wr_o;
  logic [31:0] entrada_o;
  logic [31:0] addr_o;
  logic [31:0] bits_salida_i = '0;

  secuenciador_spi #(.MAX_BYTES(256), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_bytes_i(n_bytes_i),
    .mode_i(mode_i), .tx_byte_i(tx_byte_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_byte_o(rx_byte_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .reg_sel_o(reg_sel_o), .wr_o(wr_o), .entrada_o(entrada_o), .addr_o(addr_o),
    .bits_salida_i(bits_salida_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SPI core model: buffer + control register, 1-cycle registered reads,
  // send bit clears 40 cycles after being set (unless stuck), at which point
  // the buffer holds the received bytes from rx_src.
  logic [7:0]  mem [256];
  logic [7:0]  rx_src [256];
  logic [31:0] ctrl_reg = '0;
  int          poll_cnt = 0;
  int          nwr = 0;
  int          nready = 0;
  int          ndone = 0;
  int          bad_wr = 0;
  bit          stuck = 1'b0;
  logic [63:0] wlog [$];
  logic [31:0] clog [$];

  always @(posedge clk) begin
    bits_salida_i <= reg_sel_o ? {24'h0, mem[addr_o[7:0]]} : ctrl_reg;
    if (tx_ready_o) nready <= nready + 1;
    if (done_o) ndone <= ndone + 1;
    if (wr_o) begin
      nwr <= nwr + 1;
      if (reg_sel_o) begin
        mem[addr_o[7:0]] <= entrada_o[7:0];
        wlog.push_back({addr_o, entrada_o});
        if (!tx_ready_o) bad_wr <= bad_wr + 1;
      end else begin
        ctrl_reg <= entrada_o;
        clog.push_back(entrada_o);
        poll_cnt <= (entrada_o[0] && !stuck) ? 40 : 0;
      end
    end else if (poll_cnt > 0) begin
      poll_cnt <= poll_cnt - 1;
      if (poll_cnt == 1) begin
        ctrl_reg[0] <= 1'b0;
        for (int i = 0; i < 256; i++)
          if (i <= int'(ctrl_reg[12:4])) mem[i] <= rx_src[i];
      end
    end
  end

  // Reference control word from the register-map rules.
  function automatic logic [31:0] exp_ctrl(input int n, input int mode);
    return 32'((n - 1) * 16 + ((mode == 2) ? 8 : 0) + ((mode == 1) ? 4 : 0) + 1);
  endfunction

  logic [7:0] rx_got [$];
  bit         g_done;
  logic       g_err;
  logic       g_busy_after;
  int         unstable;

  // Runs one transaction from a negedge: offers tx bytes with tx_gap idle
  // cycles between them, holds rx_ready low rx_stall cycles per byte, records
  // accepted rx bytes, the done pulse and error_o at done.
  task automatic run_txn(input int n, input logic [1:0] mode, input logic [7:0] txb[$],
                         input int tx_gap, input int rx_stall);
    int idx, gapc, stallc;
    logic [7:0] hold;
    bit stalled;
    rx_got.delete();
    g_done = 0; g_err = 1'b0; unstable = 0;
    idx = 0; gapc = tx_gap; stallc = rx_stall; stalled = 0; hold = '0;
    start_i = 1'b1; n_bytes_i = 9'(n); mode_i = mode;
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !g_done; cyc++) begin
      if (done_o) begin g_done = 1; g_err = error_o; end
      tx_valid_i = 1'b0;
      if (idx < txb.size()) begin
        if (gapc > 0) gapc--;
        else begin
          tx_valid_i = 1'b1; tx_byte_i = txb[idx];
          if (tx_ready_o) begin idx++; gapc = tx_gap; end
        end
      end
      rx_ready_i = 1'b1;
      if (rx_valid_o) begin
        if (stalled && rx_byte_o !== hold) unstable++;
        if (stallc > 0) begin
          rx_ready_i = 1'b0; stallc--; stalled = 1; hold = rx_byte_o;
        end else begin
          rx_got.push_back(rx_byte_o); stallc = rx_stall; stalled = 0;
        end
      end
      @(negedge clk);
    end
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b1;
    g_busy_after = busy_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_ready_o, rx_valid_o, busy_o, done_o, error_o, reg_sel_o, wr_o, rx_byte_o,
         entrada_o, addr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b wr=%0b sel=%0b data=%h addr=%h want all 0",
               busy_o, done_o, error_o, wr_o, reg_sel_o, entrada_o, addr_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || wr_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b wr=%0b want 0 0", busy_o, wr_o);
    end
  endtask

  task automatic test_transfer();
    logic [7:0] txb [$];
    int w0, c0;
    txb = '{8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 3; i++) rx_src[i] = 8'($urandom);
    w0 = wlog.size(); c0 = clog.size();
    run_txn(3, 2'b00, txb, 0, 0);
    checks++;
    if (g_done !== 1 || g_err !== 1'b0) begin
      failures++; $display("FAIL xfer_done: done=%0d err=%0b want 1 0", g_done, g_err);
    end
    checks++;
    if (wlog.size() - w0 != 3) begin
      failures++; $display("FAIL xfer_nwrites: got %0d want 3", wlog.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[w0 + i] !== {32'(i), 24'h0, txb[i]}) begin
          failures++; $display("FAIL xfer_write%0d: got %h want %h", i, wlog[w0 + i], {32'(i), 24'h0, txb[i]});
        end
      end
    end
    checks++;
    if (clog.size() <= c0 || clog[c0] !== 32'h0000_0021) begin
      failures++; $display("FAIL xfer_ctrl: got %h want 00000021", (clog.size() > c0) ? clog[c0] : 32'hx);
    end
    checks++;
    if (rx_got.size() != 3) begin
      failures++; $display("FAIL xfer_rxcount: got %0d want 3", rx_got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_got[i] !== rx_src[i]) begin
          failures++; $display("FAIL xfer_rx%0d: got %h want %h", i, rx_got[i], rx_src[i]);
        end
      end
    end
    checks++;
    if (g_busy_after !== 1'b0 || error_o !== 1'b0) begin
      failures++; $display("FAIL xfer_after: busy=%0b err=%0b want 0 0", g_busy_after, error_o);
    end
  endtask

  task automatic test_all_ones();
    logic [7:0] none [$];
    int w0, c0, r0, n;
    for (int i = 0; i < 256; i++) rx_src[i] = 8'($urandom);
    w0 = wlog.size(); c0 = clog.size(); r0 = nready;
    run_txn(256, 2'b01, none, 0, 0);
    checks++;
    if (g_done !== 1 || g_err !== 1'b0 || nready != r0 || wlog.size() != w0) begin
      failures++;
      $display("FAIL ones_status: done=%0d err=%0b ready_cycles=%0d data_writes=%0d want 1 0 0 0",
               g_done, g_err, nready - r0, wlog.size() - w0);
    end
    checks++;
    if (clog.size() <= c0 || clog[c0] !== 32'h0000_0FF5) begin
      failures++; $display("FAIL ones_ctrl: got %h want 00000ff5", (clog.size() > c0) ? clog[c0] : 32'hx);
    end
    checks++;
    if (rx_got.size() != 256) begin
      failures++; $display("FAIL ones_rxcount: got %0d want 256", rx_got.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (rx_got[i] !== rx_src[i]) begin
          failures++; $display("FAIL ones_rx%0d: got %h want %h", i, rx_got[i], rx_src[i]);
        end
      end
    end
    n = $urandom_range(1, 256);
    c0 = clog.size();
    run_txn(n, 2'b10, none, 0, 0);
    checks++;
    if (clog.size() <= c0 || clog[c0] !== exp_ctrl(n, 2) || rx_got.size() != n || g_err !== 1'b0) begin
      failures++;
      $display("FAIL zeros_ctrl: ctrl=%h want %h rx=%0d want %0d err=%0b",
               (clog.size() > c0) ? clog[c0] : 32'hx, exp_ctrl(n, 2), rx_got.size(), n, g_err);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] none [$];
    int ns [3];
    logic [1:0] ms [3];
    int w0;
    ns = '{0, 300, 5};
    ms = '{2'b00, 2'b00, 2'b11};
    for (int t = 0; t < 3; t++) begin
      w0 = nwr;
      run_txn(ns[t], ms[t], none, 0, 0);
      checks++;
      if (g_done !== 1 || g_err !== 1'b1 || nwr != w0 || rx_got.size() != 0) begin
        failures++;
        $display("FAIL illegal%0d: done=%0d err=%0b wr_cycles=%0d rx=%0d want 1 1 0 0",
                 t, g_done, g_err, nwr - w0, rx_got.size());
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] txb [$];
    logic [7:0] none [$];
    int c0;
    bit seen;
    txb = '{8'($urandom), 8'($urandom)};
    c0 = clog.size();
    stuck = 1'b1;
    run_txn(2, 2'b00, txb, 0, 0);
    stuck = 1'b0;
    checks++;
    if (g_done !== 1 || g_err !== 1'b1 || error_o !== 1'b1) begin
      failures++; $display("FAIL tmo_status: done=%0d err=%0b hold=%0b want 1 1 1", g_done, g_err, error_o);
    end
    checks++;
    if (clog.size() - c0 != 2 || clog[c0] !== exp_ctrl(2, 0) || clog[c0 + 1] !== 32'h0) begin
      failures++;
      $display("FAIL tmo_ctrl: writes=%0d first=%h last=%h want 2 %h 00000000",
               clog.size() - c0, (clog.size() > c0) ? clog[c0] : 32'hx,
               (clog.size() > c0 + 1) ? clog[c0 + 1] : 32'hx, exp_ctrl(2, 0));
    end
    rx_src[0] = 8'($urandom);
    start_i = 1'b1; n_bytes_i = 9'd1; mode_i = 2'b01;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL tmo_clear: err=%0b busy=%0b want 0 1", error_o, busy_o);
    end
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (done_o) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || error_o !== 1'b0) begin
      failures++; $display("FAIL tmo_recover: done=%0d err=%0b want 1 0", seen, error_o);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] txb [$];
    int w0;
    txb = '{8'($urandom), 8'($urandom)};
    rx_src[0] = 8'($urandom); rx_src[1] = 8'($urandom);
    w0 = wlog.size();
    run_txn(2, 2'b00, txb, 5, 7);
    checks++;
    if (wlog.size() - w0 != 2 || wlog[w0] !== {32'd0, 24'h0, txb[0]} || wlog[w0 + 1] !== {32'd1, 24'h0, txb[1]}) begin
      failures++; $display("FAIL bp_writes: count=%0d want 2 with bytes %h %h", wlog.size() - w0, txb[0], txb[1]);
    end
    checks++;
    if (rx_got.size() != 2 || rx_got[0] !== rx_src[0] || rx_got[1] !== rx_src[1]) begin
      failures++; $display("FAIL bp_rx: count=%0d want 2 bytes %h %h", rx_got.size(), rx_src[0], rx_src[1]);
    end
    checks++;
    if (unstable != 0 || g_err !== 1'b0 || g_done !== 1) begin
      failures++; $display("FAIL bp_stable: unstable=%0d err=%0b done=%0d want 0 0 1", unstable, g_err, g_done);
    end
  endtask

  task automatic test_random();
    logic [7:0] txb [$];
    int n, m, w0, c0, bad;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 24);
      m = $urandom_range(0, 2);
      txb.delete();
      if (m == 0) for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
      for (int i = 0; i < n; i++) rx_src[i] = 8'($urandom);
      w0 = wlog.size(); c0 = clog.size();
      run_txn(n, 2'(m), txb, $urandom_range(0, 3), $urandom_range(0, 3));
      bad = 0;
      if (wlog.size() - w0 != txb.size()) bad++;
      else for (int i = 0; i < txb.size(); i++) if (wlog[w0 + i] !== {32'(i), 24'h0, txb[i]}) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL rnd%0d_writes: bad=%0d count=%0d want %0d", t, bad, wlog.size() - w0, txb.size());
      end
      checks++;
      if (clog.size() <= c0 || clog[c0] !== exp_ctrl(n, m)) begin
        failures++; $display("FAIL rnd%0d_ctrl: got %h want %h", t, (clog.size() > c0) ? clog[c0] : 32'hx, exp_ctrl(n, m));
      end
      bad = 0;
      if (rx_got.size() != n) bad++;
      else for (int i = 0; i < n; i++) if (rx_got[i] !== rx_src[i]) bad++;
      checks++;
      if (bad != 0 || unstable != 0 || g_done !== 1 || g_err !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_rx: bad=%0d rx=%0d want %0d unstable=%0d done=%0d err=%0b",
                 t, bad, rx_got.size(), n, unstable, g_done, g_err);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int d0;
    bit seen;
    logic err;
    rx_src[0] = 8'($urandom); rx_src[1] = 8'($urandom);
    d0 = ndone;
    start_i = 1'b1; n_bytes_i = 9'd2; mode_i = 2'b01;
    @(negedge clk);
    n_bytes_i = 9'd0; mode_i = 2'b11;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL busy_set: busy=%0b want 1", busy_o);
    end
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    seen = 0; err = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (done_o) begin seen = 1; err = error_o; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || err !== 1'b0 || ndone - d0 != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore: done=%0d err=%0b pulses=%0d busy=%0b want 1 0 1 0", seen, err, ndone - d0, busy_o);
    end
  endtask

  task automatic test_reset_mid_rd();
    bit acc;
    int d0;
    for (int i = 0; i < 4; i++) rx_src[i] = 8'($urandom);
    start_i = 1'b1; n_bytes_i = 9'd4; mode_i = 2'b01;
    @(negedge clk);
    start_i = 1'b0;
    rx_ready_i = 1'b1;
    acc = 0;
    for (int c = 0; c < 500 && !acc; c++) begin
      if (rx_valid_o) acc = 1;
      @(negedge clk);
    end
    checks++;
    if (!acc) begin
      failures++; $display("FAIL rst_rd_reach: first rx byte seen=%0d want 1", acc);
    end
    d0 = ndone;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checks++;
    if ({tx_ready_o, rx_valid_o, busy_o, done_o, error_o, reg_sel_o, wr_o, rx_byte_o,
         entrada_o, addr_o} !== '0) begin
      failures++;
      $display("FAIL rst_rd_outputs: busy=%0b rxv=%0b sel=%0b wr=%0b addr=%h rx=%h want all 0",
               busy_o, rx_valid_o, reg_sel_o, wr_o, addr_o, rx_byte_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ndone != d0 || busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_rd_quiet: pulses=%0d busy=%0b rxv=%0b want 0 0 0", ndone - d0, busy_o, rx_valid_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; n_bytes_i = '0; mode_i = '0;
    tx_byte_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_transfer();
    test_all_ones();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_random();
    test_start_while_busy();
    test_reset_mid_rd();
    checks++;
    if (bad_wr != 0) begin
      failures++; $display("FAIL buffer_write_outside_load: got %0d want 0", bad_wr);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuenciador_spi.md
Name: secuenciador_spi

Overview:
- Host-side transaction sequencer for the SPI controller top; drives its register interface (reg_sel/wr/entrada/addr, reads bits_salida).
- Per transaction: loads N tx bytes into the data buffer, writes the control word with send=1, polls control[0] until the core clears it, then streams N received bytes out.
- Converts the core's raw register map into a start/busy/done handshake plus valid/ready byte streams.

Parameters:
- MAX_BYTES, 256, maximum bytes per transaction; equals buffer depth, addresses 0..MAX_BYTES-1.
- TIMEOUT_CYC, 1048576, poll cycles allowed before a transaction aborts.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin transaction; sampled only in IDLE
- n_bytes_i  in  9  byte count, legal 1..MAX_BYTES; captured on accepted start
- mode_i  in  2  00 buffer data, 01 all-ones, 10 all-zeros, 11 illegal; captured on start
- tx_byte_i  in  8  tx byte to load
- tx_valid_i  in  1  tx byte valid
- tx_ready_o  out  1  sequencer accepts tx byte this cycle
- rx_byte_o  out  8  received byte
- rx_valid_o  out  1  rx_byte_o valid
- rx_ready_i  in  1  downstream accepts rx byte
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  last transaction failed; holds until next accepted start
- reg_sel_o  out  1  0 control register, 1 data buffer
- wr_o  out  1  register write strobe
- entrada_o  out  32  write data
- addr_o  out  32  buffer address, zero-extended byte index
- bits_salida_i  in  32  register read data

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0. Reset mid-transaction takes effect at the next edge, drops wr_o, discards partial data, emits no done_o.
- IDLE: busy_o=0. start_i=1 with legal n_bytes_i/mode_i latches both, clears error_o, sets busy_o next cycle.
  - mode 00 -> LOAD; mode 01/10 -> CFG.
  - Illegal start (n_bytes_i=0, n_bytes_i>MAX_BYTES, or mode 11) -> ERR: no bus write, error_o=1, done_o pulse.
  - start_i while busy_o=1 is ignored.
- LOAD (counter k=0..N-1): tx_ready_o=1.
  - On tx_valid_i&tx_ready_o, same cycle: wr_o=1, reg_sel_o=1, addr_o=k, entrada_o={24'b0,tx_byte_i}; k++.
  - After byte N-1 -> CFG. Throughput 1 byte/cycle; stalls without limit on tx_valid_i=0.
- CFG: one cycle, wr_o=1, reg_sel_o=0.
  - entrada_o: [12:4]=N-1, [3]=(mode==10), [2]=(mode==01), [1]=0, [0]=1, all other bits 0.
  - -> POLL.
- POLL: reg_sel_o=0, wr_o=0. Read latency is 1 cycle: address phase, then sample phase; no sampling in the address phase.
  - Sampled bits_salida_i[0]=0 -> RD with k=0.
  - Poll counter reaching TIMEOUT_CYC -> ABORT.
- ABORT: one cycle, wr_o=1, reg_sel_o=0, entrada_o=0 (clears send) -> ERR.
- RD: per byte k:
  - reg_sel_o=1, addr_o=k; wait 1 cycle; capture bits_salida_i[7:0] into rx_byte_o; rx_valid_o=1.
  - Hold rx_byte_o/rx_valid_o stable until rx_ready_i=1, then k++.
  - After byte N-1 is accepted -> DONE. Throughput one byte per 2 cycles minimum.
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, error_o=0 -> IDLE.
- ERR: done_o=1 for one cycle, error_o=1 (sticky) -> IDLE.
- wr_o is never asserted outside LOAD, CFG and ABORT. Address wraps never occur: k ≤ N-1 ≤ 255. Width rule: N-1 is computed on 9 bits.

Decomposition:
- Package secuenciador_spi_pkg:
  - state enum: IDLE, LOAD, CFG, POLL_A, POLL_S, ABORT, RD_A, RD_S, RD_OUT, DONE, ERR
  - mode encodings
  - control-word bit positions: SEND=0, ALL1=2, ALL0=3, NEND_LSB=4, NEND_MSB=12
- One sub-module, contador_timeout: a loadable down-counter with expiry flag for the poll timeout.

Test Plan:
1. Data transfer: N=3, mode 00, bytes A5,3C,FF with rx_ready_i=1 → writes addr 0..2. Control write=0x0000_0021. Poll model clears bit0 after 40 cycles. Readback yields the model's 3 bytes in order, then done_o=1 and error_o=0.
2. All-ones: N=256, mode 01 → no LOAD writes, tx_ready_o stays 0. Control word=0x0000_0FF5. 256 rx bytes read from addr 0..255.
3. Illegal start: n_bytes_i=0, then n_bytes_i=300, then mode 11 → each gives done_o pulse with error_o=1 and zero wr_o cycles.
4. Timeout: TIMEOUT_CYC=64, bit0 never clears → ABORT writes control 0x0000_0000, then done_o with error_o=1. A following legal start clears error_o.
5. Backpressure: N=2, tx_valid_i gapped 5 cycles and rx_ready_i low 7 cycles → no lost or duplicated bytes; rx_byte_o stable while stalled.
6. Reset mid-RD (k=1) → next cycle all outputs 0, state IDLE, no done_o. start_i ignored while busy_o=1.
